// File: rtl/wb_master_pkg.sv
// Shared types and default sizes for the Wishbone classic master bridge.
// Used by wb_master_bridge and wb_timeout_counter.
package wb_master_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEF_ADDR_W         = 32;
   localparam int DEF_DATA_W         = 32;
   localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/wb_timeout_counter.sv
// Watchdog for an unacknowledged Wishbone cycle; expire flags the last allowed bus cycle.
// Instantiated by wb_master_bridge only when WB_MASTER_TIMEOUT_EN is defined.
module wb_timeout_counter
   import wb_master_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expire = (count == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// Wishbone B4 classic initiator: one client command becomes one single-beat bus cycle.
// Optional watchdog abort is built when WB_MASTER_TIMEOUT_EN is defined.
module wb_master_bridge
   import wb_master_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                wb_clk_i,
   input  logic                asyncrst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_sel,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                wbm_cyc_o,
   output logic                wbm_stb_o,
   output logic                wbm_we_o,
   output logic [ADDR_W-1:0]   wbm_adr_o,
   output logic [DATA_W-1:0]   wbm_dat_o,
   output logic [DATA_W/8-1:0] wbm_sel_o,
   input  logic                wbm_ack_i,
   input  logic [DATA_W-1:0]   wbm_dat_i
);

   if (TIMEOUT_CYCLES < 1 || (DATA_W % 8) != 0) begin : g_bad_cfg
   end

   state_t state, state_nxt;
   logic   run_q;
   logic   accept, ack_bus, abort, timeout_hit;

`ifdef WB_MASTER_TIMEOUT_EN
   logic rsp_err_q;

   wb_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk   (wb_clk_i),
      .rst_n (asyncrst_n),
      .clear (accept),
      .enable((state == BUS) && !wbm_ack_i),
      .expire(timeout_hit)
   );

   assign rsp_err = rsp_err_q;
`else
   assign timeout_hit = 1'b0;
   assign rsp_err     = 1'b0;
`endif

   // run_q holds req_ready low until the first edge after reset release
   assign req_ready = run_q && (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign wbm_cyc_o = (state == BUS);
   assign wbm_stb_o = (state == BUS);

   always_ff @(posedge wb_clk_i or negedge asyncrst_n) begin
      if (!asyncrst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      ack_bus   = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               accept    = 1'b1;
               state_nxt = BUS;
            end
         end
         BUS: begin
            // ack takes priority over a watchdog expiring in the same cycle
            if (wbm_ack_i) begin
               ack_bus   = 1'b1;
               state_nxt = RESP;
            end else if (timeout_hit) begin
               abort     = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge asyncrst_n) begin
      if (!asyncrst_n) begin
         run_q     <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
         wbm_sel_o <= '0;
         rsp_rdata <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
         rsp_err_q <= 1'b0;
`endif
      end else begin
         run_q <= 1'b1;
         if (accept) begin
            wbm_we_o  <= req_we;
            wbm_adr_o <= req_addr;
            wbm_dat_o <= req_wdata;
            wbm_sel_o <= req_sel;
         end
         if (ack_bus) begin
            rsp_rdata <= wbm_we_o ? '0 : wbm_dat_i;
         end else if (abort) begin
            rsp_rdata <= '0;
         end
`ifdef WB_MASTER_TIMEOUT_EN
         if (ack_bus) begin
            rsp_err_q <= 1'b0;
         end else if (abort) begin
            rsp_err_q <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge; timeout cases follow WB_MASTER_TIMEOUT_EN.
module tb_wb_master_bridge;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          asyncrst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [SW-1:0] req_sel = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [AW-1:0] wbm_adr_o;
   logic [DW-1:0] wbm_dat_o;
   logic [SW-1:0] wbm_sel_o;
   logic          wbm_ack_i = 1'b0;
   logic [DW-1:0] wbm_dat_i = '0;

   always #5 clk = ~clk;

   wb_master_bridge #(
      .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)
   ) dut (
      .wb_clk_i(clk), .asyncrst_n(asyncrst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
      .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // waits = cycles of cyc before ack; -1 means the responder never acks
   typedef struct {
      logic          we;
      logic [AW-1:0] adr;
      logic [DW-1:0] wdat;
      logic [SW-1:0] sel;
      int            waits;
      logic [DW-1:0] rdat;
      int            exp_cyc;
      logic          exp_err;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic run_txn(input vec_t v, input string tag);
      int n;
      bit hold_ok;
      chk({tag, ".req_ready_before"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_we    = v.we;
      req_addr  = v.adr;
      req_wdata = v.wdat;
      req_sel   = v.sel;
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = ~v.adr;
      req_wdata = ~v.wdat;
      req_sel   = ~v.sel;
      req_we    = ~v.we;
      n = 0;
      hold_ok = 1'b1;
      while (wbm_cyc_o && n < 2000) begin
         n++;
         if (wbm_stb_o !== 1'b1 || wbm_we_o !== v.we || wbm_adr_o !== v.adr ||
             wbm_dat_o !== v.wdat || wbm_sel_o !== v.sel || req_ready !== 1'b0 ||
             rsp_valid !== 1'b0)
            hold_ok = 1'b0;
         wbm_ack_i = (n == v.waits + 1);
         wbm_dat_i = v.rdat;
         @(negedge clk);
      end
      wbm_ack_i = 1'b0;
      wbm_dat_i = '0;
      chk({tag, ".cyc_cycles"}, 64'(n), 64'(v.exp_cyc));
      chk({tag, ".bus_hold"}, 64'(hold_ok), 64'd1);
      chk({tag, ".stb_low"}, 64'(wbm_stb_o), 64'd0);
      chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, ".rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
      chk({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, ".rsp_valid_drop"}, 64'(rsp_valid), 64'd0);
      chk({tag, ".req_ready_after"}, 64'(req_ready), 64'd1);
   endtask

   initial begin
      #1ms;
      $display("FAIL global_timeout: got hang, expected completion");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      int cyc_seen;
      vecs.push_back(vec_t'{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'hA5A5_A5A5, 1, 1'b0, 32'h0});
      vecs.push_back(vec_t'{1'b0, 32'h1000_0010, 32'h0, 4'hF, 3, 32'h1234_5678, 4, 1'b0, 32'h1234_5678});
      vecs.push_back(vec_t'{1'b0, 32'h0000_0002, 32'h0, 4'h3, 0, 32'hCAFE_F00D, 1, 1'b0, 32'hCAFE_F00D});
      vecs.push_back(vec_t'{1'b1, 32'h4000_0100, 32'h0102_0304, 4'h5, 1, 32'hFFFF_FFFF, 2, 1'b0, 32'h0});
`ifdef WB_MASTER_TIMEOUT_EN
      vecs.push_back(vec_t'{1'b0, 32'h5000_0000, 32'h0, 4'hF, -1, 32'hFFFF_FFFF, 8, 1'b1, 32'h0});
      vecs.push_back(vec_t'{1'b0, 32'h5000_0004, 32'h0, 4'hF, 7, 32'h0BAD_F00D, 8, 1'b0, 32'h0BAD_F00D});
      vecs.push_back(vec_t'{1'b1, 32'h5000_0008, 32'h7777_0000, 4'hC, -1, 32'h0, 8, 1'b1, 32'h0});
`else
      vecs.push_back(vec_t'{1'b0, 32'h6000_0000, 32'h0, 4'hF, 1000, 32'h55AA_55AA, 1001, 1'b0, 32'h55AA_55AA});
`endif

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("reset.ctrl", {58'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err, req_ready}, 64'd0);
      chk("reset.adr_sel", {28'd0, wbm_adr_o, wbm_sel_o}, 64'd0);
      chk("reset.data", {wbm_dat_o, rsp_rdata}, 64'd0);
      asyncrst_n = 1'b1;
      chk("reset.ready_before_edge", 64'(req_ready), 64'd0);
      @(negedge clk);
      chk("reset.ready_after_edge", 64'(req_ready), 64'd1);

      // ack while idle must be ignored
      wbm_ack_i = 1'b1;
      @(negedge clk);
      wbm_ack_i = 1'b0;
      chk("idle_ack.cyc", 64'(wbm_cyc_o), 64'd0);
      chk("idle_ack.rsp_valid", 64'(rsp_valid), 64'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
      end

      // back-pressure: response held while a new request waits
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h2000_0000;
      req_sel   = 4'hF;
      @(negedge clk);
      chk("bp.cyc", 64'(wbm_cyc_o), 64'd1);
      wbm_ack_i = 1'b1;
      wbm_dat_i = 32'h89AB_CDEF;
      @(negedge clk);
      wbm_ack_i = 1'b0;
      wbm_dat_i = '0;
      cyc_seen = 0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp.rsp_valid%0d", i), 64'(rsp_valid), 64'd1);
         chk($sformatf("bp.rdata%0d", i), 64'(rsp_rdata), 64'h89AB_CDEF);
         chk($sformatf("bp.req_ready%0d", i), 64'(req_ready), 64'd0);
         if (wbm_cyc_o) cyc_seen++;
         @(negedge clk);
      end
      chk("bp.no_second_cyc", 64'(cyc_seen), 64'd0);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("bp.released", {62'd0, rsp_valid, req_ready}, 64'd1);

      // asynchronous reset in the middle of a bus cycle
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h3000_0008;
      req_wdata = 32'h1111_2222;
      req_sel   = 4'hF;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst_mid.cyc_before", 64'(wbm_cyc_o), 64'd1);
      #2 asyncrst_n = 1'b0;
      #1;
      chk("rst_mid.cyc_stb", {62'd0, wbm_cyc_o, wbm_stb_o}, 64'd0);
      chk("rst_mid.adr", 64'(wbm_adr_o), 64'd0);
      chk("rst_mid.ready_valid", {62'd0, req_ready, rsp_valid}, 64'd0);
      @(negedge clk);
      asyncrst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid.ready_after", 64'(req_ready), 64'd1);
      chk("rst_mid.no_rsp", {62'd0, rsp_valid, wbm_cyc_o}, 64'd0);
      run_txn(vec_t'{1'b0, 32'h0000_0040, 32'h0, 4'hF, 2, 32'h0F0F_0F0F, 3, 1'b0, 32'h0F0F_0F0F}, "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_master_bridge.md
# wb_master_bridge

Wishbone classic initiator that turns single-beat commands from an on-chip client into Wishbone B4 classic read/write cycles. It is the master-side counterpart to the chip's Wishbone slave port. It sits between a client in the bASIC top level, such as the UART debug engine, and any Wishbone responder. A cycle that gets no acknowledge can be terminated by an optional watchdog.

## Interface
- ADDR_W, 32, Wishbone address width
- DATA_W, 32, Wishbone data width; must be a multiple of 8
- TIMEOUT_CYCLES, 255, cycles of unacknowledged `cyc` before abort; must be ≥1
- wb_clk_i  input  1  bus clock; all logic on rising edge
- asyncrst_n  input  1  reset, asynchronous assert, active-low
- req_valid  input  1  client command valid
- req_ready  output  1  bridge can accept a command
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  byte address
- req_wdata  input  DATA_W  write data
- req_sel  input  DATA_W/8  byte lane enables
- rsp_valid  output  1  response valid
- rsp_ready  input  1  client accepts response
- rsp_rdata  output  DATA_W  read data; 0 for writes and errors
- rsp_err  output  1  cycle aborted by timeout
- wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone master controls
- wbm_adr_o  output  ADDR_W; wbm_dat_o  output  DATA_W; wbm_sel_o  output  DATA_W/8
- wbm_ack_i  input  1; wbm_dat_i  input  DATA_W

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid & req_ready`, register `we`/`adr`/`dat`/`sel` onto the `wbm_*` outputs, assert `cyc`=`stb`=1, clear the timeout counter, go to BUS.
- BUS:
  - `cyc`/`stb`/`adr`/`we`/`dat`/`sel` are held stable.
  - `wbm_ack_i` sampled high:
    - deassert `cyc`/`stb`.
    - capture `wbm_dat_i` into `rsp_rdata` for reads; 0 for writes.
    - `rsp_err`=0; go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES−1 with no ack:
    - deassert `cyc`/`stb`.
    - `rsp_err`=1, `rsp_rdata`=0; go to RESP.
- RESP:
  - `rsp_valid`=1, with data and err held stable.
  - On `rsp_ready`, return to IDLE.
  - `req_ready` stays 0 until IDLE, so there is never more than one command outstanding.
- Simultaneous events:
  - Ack and timeout in the same cycle: ack wins and `rsp_err`=0.
  - Ack in IDLE or RESP is ignored.
- Reset:
  - Every output goes to 0 immediately: `cyc`, `stb`, `we`, `adr`, `dat`, `sel`, `rsp_*`, `req_ready`.
  - FSM returns to IDLE.
  - A cycle in flight is dropped with no response. `req_ready` becomes 1 on the first clock edge after release.

## Timing
- Accept at edge N → `cyc`/`stb` high during cycle N+1.
- Zero-wait responder (ack high in cycle N+1) → `cyc` low and `rsp_valid` high in cycle N+2.
- Minimum turnaround is 3 cycles per command: accept, bus, response with `rsp_ready`=1.
- Timeout: `cyc` is high for exactly TIMEOUT_CYCLES cycles, then `rsp_valid` rises with `rsp_err`=1.
- No combinational path from any input to any output except `req_ready`, which is a decode of the registered state.

## Configuration
- `WB_MASTER_TIMEOUT_EN`
  - Defined: the watchdog, counter and `rsp_err`=1 path are built as described.
  - Undefined: the counter is not instantiated, `rsp_err` is tied to 0, and BUS waits on ack indefinitely. TIMEOUT_CYCLES is ignored.

## Structure
- Package `wb_master_pkg` holds:
  - FSM state enum (IDLE, BUS, RESP).
  - Default width constants ADDR_W/DATA_W.
  - Default TIMEOUT_CYCLES.
- Sub-module `wb_timeout_counter`:
  - Ports: clear, enable, expire.
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Instantiated only under `WB_MASTER_TIMEOUT_EN`.

## Test plan
- Write, zero-wait responder:
  - Stimulus: `req_we`=1, `adr`=0x3000_0004, `wdata`=0xDEADBEEF, `sel`=0xF.
  - Response: one `cyc` cycle with matching `wbm_*` values; `rsp_valid` 2 cycles after accept, `rsp_err`=0, `rsp_rdata`=0.
- Read, 3 wait states:
  - Stimulus: responder returns 0x1234_5678.
  - Response: `cyc`/`stb` high exactly 4 cycles, `rsp_rdata`=0x1234_5678.
- Back-pressure:
  - Stimulus: `rsp_ready` held low 5 cycles while `req_valid` stays high.
  - Response: `rsp_valid` and data stable, `req_ready`=0 throughout, no second `cyc`.
- Timeout (macro defined, TIMEOUT_CYCLES=8):
  - Stimulus: responder never acks.
  - Response: `cyc` high exactly 8 cycles, then `rsp_err`=1, `rsp_rdata`=0.
  - Repeat with ack on the 8th cycle: `rsp_err`=0.
- Reset mid-operation:
  - Stimulus: `asyncrst_n` low during BUS, between clock edges.
  - Response: `cyc`/`stb` drop within the same cycle, no `rsp_valid`, next command runs normally.
- Macro undefined:
  - Stimulus: no ack for 1000 cycles.
  - Response: `cyc` stays high, `rsp_err` never asserts.
